hazard_scoreboard: RTL

Parametrised hazard and forwarding controller for the 5-stage pipelined core. It keeps its own shadow of destination and write-back attributes for the E, M and W stages, and drives every operand-forwarding, stall and flush control. New over the previous hazard logic: a multi-cycle execute mode (E holds for `MC_LAT` cycles), a stall-only mode selected with `FWD_EN=0`, and a "result-not-ready" stall for any non-ALU result (load and PC+4).

---
 rtl/pipe_pkg.sv | 43 ++++
 rtl/mc_busy_fsm.sv | 44 ++++
 rtl/hazard_scoreboard.sv | 109 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the hazard scoreboard: result sources, forward selects,
// per-stage shadow record and the match helpers used by the forwarding/stall logic.
package pipe_pkg;

  // Widest register address carried in a shadow; register addresses are zero-extended to it.
  localparam int unsigned MAX_RW = 8;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } res_src_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    StIdle,
    StBusy
  } mc_state_e;

  typedef struct packed {
    logic [MAX_RW-1:0] rd;
    logic              regwrite;
    res_src_e          resultsrc;
    logic              mc;
  } shadow_t;

  // x0 is hardwired, so a zero source never matches a producer.
  function automatic logic src_hit(shadow_t s, logic [MAX_RW-1:0] src);
    return s.regwrite && (src != '0) && (s.rd == src);
  endfunction

  function automatic fwd_sel_e fwd_sel(shadow_t m, shadow_t w, logic [MAX_RW-1:0] src);
    if (src_hit(m, src) && (m.resultsrc == RES_ALU)) return FWD_M;
    if (src_hit(w, src)) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/mc_busy_fsm.sv
// Multi-cycle execute tracker: holds E for MC_LAT cycles once a multi-cycle op is seen in E.
module mc_busy_fsm
  import pipe_pkg::*;
#(
  parameter int unsigned MC_LAT = 4,
  localparam int unsigned CW = $clog2(MC_LAT)
) (
  input  logic clk,
  input  logic reset,
  input  logic McE,
  output logic busy
);

  mc_state_e     state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= StIdle;
      cnt   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (McE) begin
            state <= StBusy;
            cnt   <= CW'(MC_LAT - 2);
          end
        end
        StBusy: begin
          if (cnt == '0) begin
            state <= StIdle;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
      endcase
    end
  end

  // The op's first E cycle is already busy while the state register is still IDLE;
  // the final BUSY cycle (cnt==0) releases E so the op advances on the next edge.
  assign busy = ((state == StIdle) && McE) || ((state == StBusy) && (cnt != '0));

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller for the 5-stage core: shadows E/M/W destination attributes
// and derives forwarding selects, stalls and flushes combinationally from them and the D inputs.
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int unsigned NREG   = 32,
  parameter int unsigned MC_LAT = 4,
  parameter bit          FWD_EN = 1'b1,
  localparam int unsigned RW    = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [RW-1:0] Rs1D,
  input  logic [RW-1:0] Rs2D,
  input  logic [RW-1:0] RdD,
  input  logic          RegWriteD,
  input  logic [1:0]    ResultSrcD,
  input  logic          McD,
  input  logic          PCSrcE,
  output logic [1:0]    ForwardAE,
  output logic [1:0]    ForwardBE,
  output logic          StallF,
  output logic          StallD,
  output logic          StallE,
  output logic          FlushD,
  output logic          FlushE,
  output logic          FlushM,
  output logic [RW-1:0] RdE,
  output logic [RW-1:0] RdM,
  output logic [RW-1:0] RdW
);

  shadow_t           sh_d, sh_e, sh_m, sh_w;
  logic [MAX_RW-1:0] rs1_d, rs2_d, rs1_e, rs2_e;
  logic              busy, cf_flush, e_hit, m_hit, nr_hit, haz, stalld_q;

  assign rs1_d = MAX_RW'(Rs1D);
  assign rs2_d = MAX_RW'(Rs2D);
  assign sh_d  = '{rd: MAX_RW'(RdD), regwrite: RegWriteD,
                   resultsrc: res_src_e'(ResultSrcD), mc: McD};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_e     <= '0;
      sh_m     <= '0;
      sh_w     <= '0;
      rs1_e    <= '0;
      rs2_e    <= '0;
      stalld_q <= 1'b0;
    end else begin
      if (FlushE) begin
        sh_e  <= '0;
        rs1_e <= '0;
        rs2_e <= '0;
      end else if (!StallE) begin
        sh_e  <= sh_d;
        rs1_e <= rs1_d;
        rs2_e <= rs2_d;
      end
      sh_m     <= StallE ? shadow_t'('0) : sh_e;
      sh_w     <= sh_m;
      stalld_q <= StallD;
    end
  end

  mc_busy_fsm #(
    .MC_LAT(MC_LAT)
  ) u_mc_fsm (
    .clk  (clk),
    .reset(reset),
    .McE  (sh_e.mc),
    .busy (busy)
  );

  assign e_hit = src_hit(sh_e, rs1_d) || src_hit(sh_e, rs2_d);
  assign m_hit = src_hit(sh_m, rs1_d) || src_hit(sh_m, rs2_d);

  if (FWD_EN) begin : g_fwd
    // A D op already held once behind this producer in E picks it up from W, so the M-stage
    // check only catches a non-ALU producer the D op has not yet waited for.
    assign nr_hit = (e_hit && (sh_e.resultsrc != RES_ALU)) ||
                    (m_hit && (sh_m.resultsrc != RES_ALU) && !stalld_q);
    assign ForwardAE = fwd_sel(sh_m, sh_w, rs1_e);
    assign ForwardBE = fwd_sel(sh_m, sh_w, rs2_e);
  end else begin : g_stall_only
    // The register file writes before it reads, so W needs no interlock here.
    assign nr_hit    = e_hit || m_hit;
    assign ForwardAE = FWD_RF;
    assign ForwardBE = FWD_RF;
  end

  assign haz      = nr_hit && !busy;
  assign cf_flush = PCSrcE && !busy;

  assign StallF = busy || (haz && !cf_flush);
  assign StallD = busy || (haz && !cf_flush);
  assign StallE = busy;
  assign FlushD = cf_flush;
  assign FlushE = cf_flush || haz;
  assign FlushM = busy;

  assign RdE = sh_e.rd[RW-1:0];
  assign RdM = sh_m.rd[RW-1:0];
  assign RdW = sh_w.rd[RW-1:0];

  logic unused_fields;
  assign unused_fields = ^{sh_m.mc, sh_w.mc, sh_w.resultsrc, rs1_e, rs2_e, stalld_q};

endmodule
